// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register, field decode and multi-cycle control FSM for the regfile/ALU datapath
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        write,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WREG,
    S_WIMM
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic       is_alu, is_mov_imm, is_mov_reg, is_mvn, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign rm     = ir_q[2:0];

  assign is_alu     = (opcode == 3'b101);
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);

  // Field-derived outputs follow IR directly; the FSM only gates the enables.
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign shift  = ir_q[4:3];
  assign ALUop  = is_alu ? op : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    write    = 1'b0;

    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (load) ir_d = in;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Unsupported encodings fall straight back to WAIT with no side effects.
        if (is_mov_imm)                state_d = S_WIMM;
        else if (is_mov_reg || is_mvn) state_d = S_GETB;
        else if (is_alu)               state_d = S_GETA;
        else                           state_d = S_WAIT;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GETB;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        loadc   = 1'b1;
        asel    = is_mov_reg;
        loads   = is_cmp;
        state_d = is_cmp ? S_WAIT : S_WREG;
      end
      S_WREG: begin
        writenum = rd;
        vsel     = 2'b00;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WIMM: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller
module tb_cpu_controller;

  logic        clk, reset, s, load;
  logic [15:0] in;
  logic        w, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .write(write), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  rn;
    logic [2:0]  wn;
    logic [1:0]  vsel;
    logic        la, lb, lc, ls, as, bs, wr;
    logic [1:0]  sh;
    logic [1:0]  alu;
    logic [15:0] sx8;
    logic [15:0] sx5;
  } ctrl_t;

  ctrl_t sb[$];
  ctrl_t got, exp_v;
  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_sh, exp_alu;
  logic [15:0] exp_sx8, exp_sx5;

  function automatic ctrl_t obs();
    return {w, readnum, writenum, vsel, loada, loadb, loadc, loads, asel, bsel,
            write, shift, ALUop, sximm8, sximm5};
  endfunction

  function automatic ctrl_t mk(logic ww, logic [2:0] rn, logic [2:0] wn, logic [1:0] vs,
                               logic la, logic lb, logic lc, logic ls, logic as, logic wr);
    return {ww, rn, wn, vs, la, lb, lc, ls, as, 1'b0, wr, exp_sh, exp_alu, exp_sx8, exp_sx5};
  endfunction

  task automatic start_instr(input logic [15:0] instr);
    @(negedge clk);
    load = 1'b1; in = instr; s = 1'b0;
    @(negedge clk);
    load = 1'b0; s = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0;
    repeat (2) @(negedge clk);
    exp_sh = 2'b00; exp_alu = 2'b00; exp_sx8 = 16'h0000; exp_sx5 = 16'h0000;
    exp_v = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    got = obs();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, exp_v);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mov_imm();
    exp_sh = 2'b11; exp_alu = 2'b00; exp_sx8 = 16'hFFFE; exp_sx5 = 16'hFFFE;
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 1));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    start_instr(16'hD1FE);
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 1) s = 1'b0;
      exp_v = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL mov_imm cyc%0d got=%h exp=%h", n, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_add();
    exp_sh = 2'b01; exp_alu = 2'b00; exp_sx8 = 16'h0048; exp_sx5 = 16'h0008;
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0));
    sb.push_back(mk(0, 0, 2, 2'b00, 0, 0, 0, 0, 0, 1));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    start_instr(16'hA148);
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 1) s = 1'b0;
      exp_v = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL add cyc%0d got=%h exp=%h", n, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cmp();
    exp_sh = 2'b00; exp_alu = 2'b01; exp_sx8 = 16'h0001; exp_sx5 = 16'h0001;
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    start_instr(16'hA801);
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 1) s = 1'b0;
      exp_v = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL cmp cyc%0d got=%h exp=%h", n, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mvn(input bit pulse_load);
    exp_sh = 2'b00; exp_alu = 2'b11; exp_sx8 = 16'h0060; exp_sx5 = 16'h0000;
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0));
    sb.push_back(mk(0, 0, 3, 2'b00, 0, 0, 0, 0, 0, 1));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    start_instr(16'hB860);
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 1) s = 1'b0;
      if (pulse_load) begin
        if (n == 3) begin load = 1'b1; in = 16'hD007; end
        if (n == 4) load = 1'b0;
      end
      exp_v = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL mvn%0d cyc%0d got=%h exp=%h", pulse_load, n, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mov_reg();
    exp_sh = 2'b00; exp_alu = 2'b00; exp_sx8 = 16'hFFE5; exp_sx5 = 16'h0005;
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 5, 0, 2'b00, 0, 1, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0));
    sb.push_back(mk(0, 0, 7, 2'b00, 0, 0, 0, 0, 0, 1));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    start_instr(16'hC0E5);
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 1) s = 1'b0;
      exp_v = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL mov_reg cyc%0d got=%h exp=%h", n, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_sh = 2'b11; exp_alu = 2'b00; exp_sx8 = 16'hFFFE; exp_sx5 = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 1));
    end
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    start_instr(16'hD1FE);
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 4) s = 1'b0;
      exp_v = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL b2b cyc%0d got=%h exp=%h", n, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_sh = 2'b01; exp_alu = 2'b00; exp_sx8 = 16'h0048; exp_sx5 = 16'h0008;
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0));
    start_instr(16'hA148);
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 1) s = 1'b0;
      exp_v = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL rst_pre cyc%0d got=%h exp=%h", n, got, exp_v);
      end
      if (sb.size() > 0) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_sh = 2'b00; exp_alu = 2'b00; exp_sx8 = 16'h0000; exp_sx5 = 16'h0000;
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 0) s = 1'b1;
      if (n == 1) s = 1'b0;
      exp_v = sb.pop_front();
      got = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL rst_post cyc%0d got=%h exp=%h", n, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn(1'b0);
    test_mvn(1'b1);
    test_mov_reg();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
